shift_ctrl_8bits: RTL and testbench
===================================

SHIFT_CTRL_8BITS -- requirements
Module: shift_ctrl_8bits

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port data_in  input  8  byte offered for serialization.
REQ-004 SHALL have port data_valid  input  1  data_in valid; transfer when data_valid && data_ready at a rising edge.
REQ-005 SHALL have port data_ready  output  1  controller can accept a byte.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the transfer in progress.
REQ-007 SHALL have port fill_bit  input  1  bit inserted at LSB on each data shift.
REQ-008 SHALL have port reg_D  output  8  parallel load value for the downstream 8-bit shift register.
REQ-009 SHALL have port reg_load  output  1  load strobe to the register.
REQ-010 SHALL have port reg_shift  output  1  shift strobe to the register.
REQ-011 SHALL have port reg_shift_in  output  1  serial bit driven into the register LSB.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port bit_cnt  output  4  number of shifts completed in the current transfer.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of a completed transfer.

Function
REQ-015 SHALL implement the FSM IDLE -> LOAD -> SHIFT -> [PARITY] -> DONE -> IDLE, with registered outputs.
REQ-016 IDLE: data_ready=1; on handshake, capture data_in into hold register and go to LOAD.
REQ-017 LOAD (1 cycle): reg_load=1, reg_D=hold, reg_shift=0, bit_cnt=0; next state SHIFT.
REQ-018 SHIFT: reg_shift=1, reg_load=0, reg_shift_in=fill_bit; bit_cnt increments once per cycle.
REQ-019 SHIFT SHALL last exactly 8 cycles; after the 8th, bit_cnt=8 and next state is DONE, or PARITY when REQ-030 applies.
REQ-020 DONE (1 cycle): done=1, reg_shift=0; next state IDLE; bit_cnt holds 8 until IDLE.
REQ-021 data_ready SHALL be 0 in every state except IDLE; data_valid outside IDLE is ignored and the byte is not consumed.
REQ-022 reg_load and reg_shift SHALL never be high in the same cycle.
REQ-023 Latency: done SHALL assert on the 10th rising edge after the accepting edge (11th with parity).
REQ-024 abort=1 in LOAD/SHIFT/PARITY SHALL return the FSM to IDLE on the next edge, with strobes low, bit_cnt=0 and no done pulse.
REQ-025 abort in IDLE or DONE SHALL have no effect; DONE still pulses done.
REQ-026 A back-to-back byte SHALL be accepted only in IDLE; minimum spacing is 11 cycles between accepts (12 with parity).
REQ-027 reg_D SHALL hold the last captured byte outside LOAD; it is 0x00 until the first capture.

Reset
REQ-028 While rst=1: state=IDLE, hold=0x00, reg_D=0x00, reg_load=0, reg_shift=0, reg_shift_in=0, bit_cnt=0, done=0, busy=0, data_ready=1.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer immediately; no done pulse follows.

Configuration
REQ-030 With macro SHIFT_CTRL_PARITY_EN defined: a PARITY state (1 cycle) follows SHIFT, with reg_shift=1, reg_shift_in = XOR of the 8 hold bits (even parity), and bit_cnt=9.
REQ-031 Without SHIFT_CTRL_PARITY_EN: no PARITY state exists, SHIFT goes directly to DONE, and bit_cnt never exceeds 8.

Verification
REQ-032 Reset, then send byte 0xA5 with fill_bit=0 -> LOAD with reg_D=0xA5 at edge 1; 8 reg_shift cycles; done at edge 10; data_ready=0 throughout.
REQ-033 data_valid held high with 0x3C then 0xC3 -> 0x3C accepted; 0xC3 not accepted until IDLE; second LOAD exactly 11 cycles after the first.
REQ-034 abort=1 when bit_cnt=4 -> IDLE next edge, bit_cnt=0, no done pulse; data_ready=1.
REQ-035 rst pulsed during SHIFT (bit_cnt=6) -> all outputs at reset values asynchronously; no done pulse.
REQ-036 SHIFT_CTRL_PARITY_EN defined, byte 0x07 -> 9th shift with reg_shift_in=1 and bit_cnt=9; done at edge 11. Byte 0x03 -> reg_shift_in=0 in PARITY.
REQ-037 fill_bit=1 for 0x00 -> reg_shift_in=1 on all 8 data shifts; the modeled register reads 0xFF after done.

Source files
------------

// File: rtl/shift_ctrl_8bits_if.sv
// rtl/shift_ctrl_8bits_if.sv - byte handshake interface into the serializing shift controller
interface shift_ctrl_8bits_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/shift_ctrl_8bits.sv
// rtl/shift_ctrl_8bits.sv - drives load/shift strobes of an external 8-bit shift register
// Optional even-parity bit after the data shifts when SHIFT_CTRL_PARITY_EN is defined.
module shift_ctrl_8bits (
  input  logic                    clk,
  input  logic                    rst,
  shift_ctrl_8bits_if.slave       in_if,
  input  logic                    abort,
  input  logic                    fill_bit,
  output logic [7:0]              reg_D,
  output logic                    reg_load,
  output logic                    reg_shift,
  output logic                    reg_shift_in,
  output logic                    busy,
  output logic [3:0]              bit_cnt,
  output logic                    done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] load_val_q, load_val_d;
  logic       load_q, load_d;
  logic       shift_q, shift_d;
  logic       shift_in_q, shift_in_d;
  logic       done_q, done_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;

  assign accept = in_if.data_valid && (state_q == S_IDLE);

  // Strobes are registered from the current state, so they trail the state register by one edge.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    load_val_d = load_val_q;
    load_d     = 1'b0;
    shift_d    = 1'b0;
    shift_in_d = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (accept) begin
          hold_d  = in_if.data_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_val_d = hold_q;
        cnt_d      = 4'd0;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          load_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          shift_d    = 1'b1;
          shift_in_d = fill_bit;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
`ifdef SHIFT_CTRL_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      S_PARITY: begin
        if (abort) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          shift_d    = 1'b1;
          shift_in_d = ^hold_q;
          cnt_d      = cnt_q + 4'd1;
          state_d    = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= 8'h00;
      load_val_q <= 8'h00;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      shift_in_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      load_val_q <= load_val_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
      shift_in_q <= shift_in_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_if.data_ready = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign reg_D            = load_val_q;
  assign reg_load         = load_q;
  assign reg_shift        = shift_q;
  assign reg_shift_in     = shift_in_q;
  assign bit_cnt          = cnt_q;
  assign done             = done_q;

endmodule

// File: tb/tb_shift_ctrl_8bits.sv
// tb/tb_shift_ctrl_8bits.sv - directed self-checking bench for shift_ctrl_8bits
module tb_shift_ctrl_8bits;

`ifdef SHIFT_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DONE_EDGE = 10 + P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       fill_bit = 1'b0;
  logic [7:0] reg_D;
  logic       reg_load, reg_shift, reg_shift_in, busy, done;
  logic [3:0] bit_cnt;
  logic [7:0] model_q;
  int         n_checks = 0;
  int         n_fail = 0;

  shift_ctrl_8bits_if bus ();

  shift_ctrl_8bits dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .abort        (abort),
    .fill_bit     (fill_bit),
    .reg_D        (reg_D),
    .reg_load     (reg_load),
    .reg_shift    (reg_shift),
    .reg_shift_in (reg_shift_in),
    .busy         (busy),
    .bit_cnt      (bit_cnt),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit register, clocked once per cycle by the strobes.
  always @(negedge clk or posedge rst) begin
    if (rst)            model_q <= 8'h00;
    else if (reg_load)  model_q <= reg_D;
    else if (reg_shift) model_q <= {model_q[6:0], reg_shift_in};
  end

  // {data_ready, busy, done, reg_load, reg_shift, reg_shift_in, bit_cnt, reg_D}
  function automatic logic [17:0] outs();
    return {bus.data_ready, busy, done, reg_load, reg_shift, reg_shift_in, bit_cnt, reg_D};
  endfunction

  function automatic logic [17:0] exp_vec(int k, logic [7:0] b, logic f);
    if (k == 1)             return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, b};
    if (k >= 2 && k <= 9)   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, f, 4'(k - 1), b};
    if (k == DONE_EDGE)     return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(8 + P), b};
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ^b, 4'd9, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});
    end
  endtask

  task automatic test_basic_byte(input logic [7:0] b, input logic f, input string tag);
    fill_bit       = f;
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    n_checks++;
    if (bus.data_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept got ready=%b busy=%b exp ready=0 busy=1", tag, bus.data_ready, busy);
    end
    for (int k = 1; k <= DONE_EDGE; k++) begin
      tick();
      n_checks++;
      if (outs() !== exp_vec(k, b, f)) begin
        n_fail++;
        $display("FAIL %s edge=%0d got=%h exp=%h", tag, k, outs(), exp_vec(k, b, f));
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL %s after_done got done=%b cnt=%0d exp done=0 cnt=0", tag, done, bit_cnt);
    end
  endtask

  task automatic test_fill_bit();
    logic [7:0] exp_model;
    test_basic_byte(8'h00, 1'b1, "fill");
    exp_model = (P == 1) ? 8'hFE : 8'hFF;
    n_checks++;
    if (model_q !== exp_model) begin
      n_fail++;
      $display("FAIL fill_model got=%h exp=%h", model_q, exp_model);
    end
    fill_bit = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic [7:0] first_d = 8'h00;
    bus.data_in    = 8'h3C;
    bus.data_valid = 1'b1;
    tick();
    bus.data_in = 8'hC3;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (reg_load === 1'b1 && first < 0) begin
        first   = k;
        first_d = reg_D;
      end else if (reg_load === 1'b1 && second < 0) begin
        second = k;
      end
      if (k == 11 + P) bus.data_valid = 1'b0;
      if (k >= 2 && k < DONE_EDGE) begin
        n_checks++;
        if (reg_D !== 8'h3C || bus.data_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_hold edge=%0d got reg_D=%h ready=%b exp reg_D=3c ready=0", k, reg_D, bus.data_ready);
        end
      end
    end
    n_checks++;
    if (first !== 1 || first_d !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_first got edge=%0d reg_D=%h exp edge=1 reg_D=3c", first, first_d);
    end
    n_checks++;
    if (second - first !== 11 + P) begin
      n_fail++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", second - first, 11 + P);
    end
    n_checks++;
    if (reg_D !== 8'hC3 || bus.data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end got reg_D=%h ready=%b exp reg_D=c3 ready=1", reg_D, bus.data_ready);
    end
  endtask

  task automatic test_abort_shift();
    int k;
    int saw_done = 0;
    bus.data_in    = 8'h5A;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (k = 0; k < 20 && bit_cnt !== 4'd4; k++) tick();
    n_checks++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL abort_wait got timeout exp bit_cnt=4");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h5A}) begin
      n_fail++;
      $display("FAIL abort_idle got=%h exp=%h", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h5A});
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || busy !== 1'b0) saw_done++;
    end
    n_checks++;
    if (saw_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%0d bad cycles exp=0", saw_done);
    end
  endtask

  task automatic test_abort_done_idle();
    int k;
    bus.data_in    = 8'h81;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (k = 0; k < 20 && bit_cnt !== 4'(8 + P); k++) tick();
    abort = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1 || bit_cnt !== 4'(8 + P) || k >= 20) begin
      n_fail++;
      $display("FAIL abort_in_done got done=%b cnt=%0d exp done=1 cnt=%0d", done, bit_cnt, 8 + P);
    end
    bus.data_in    = 8'h42;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_idle got busy=%b ready=%b exp busy=1 ready=0", busy, bus.data_ready);
    end
    tick();
    n_checks++;
    if (reg_load !== 1'b1 || reg_D !== 8'h42) begin
      n_fail++;
      $display("FAIL abort_idle_load got load=%b reg_D=%h exp load=1 reg_D=42", reg_load, reg_D);
    end
    for (k = 0; k < 20 && done !== 1'b1; k++) tick();
    n_checks++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL abort_idle_done got timeout exp done");
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int k;
    int bad = 0;
    bus.data_in    = 8'h96;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (k = 0; k < 20 && bit_cnt !== 4'd6; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00} || k >= 20) begin
      n_fail++;
      $display("FAIL reset_mid got=%h exp=%h", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got=%0d bad cycles exp=0", bad);
    end
  endtask

`ifdef SHIFT_CTRL_PARITY_EN
  task automatic test_parity();
    test_basic_byte(8'h07, 1'b0, "parity07");
    test_basic_byte(8'h03, 1'b0, "parity03");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    test_reset();
    test_basic_byte(8'hA5, 1'b0, "basic_a5");
    test_basic_byte(8'h5C, 1'b0, "basic_5c");
    test_back_to_back();
    test_abort_shift();
    test_abort_done_idle();
    test_reset_mid();
    test_fill_bit();
`ifdef SHIFT_CTRL_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
